// File: rtl/grid_world.sv
// grid_world: a robot walking on a ROWS x COLS cell map.
//
// The block owns the map, the robot pose and a five-state step sequencer
// (IDLE -> SENSE -> LOW -> HIGH -> APPLY -> SENSE ...). Each step drives one
// robot_clock pulse. The robot's front/turn/remove command is sampled once,
// in APPLY, and the sensors it sees are the values captured in SENSE.
//
// Ports:
//   clock, reset                  system clock, async active-low reset
//   start, stop                   start pulse (IDLE only), stop level (acts at APPLY)
//   init_row/col/dir              start pose, latched on start
//   load_en/row/col/data          map write port, active only in IDLE
//   rd_row/col -> rd_cell         registered map read port, usable in any state
//   front, turn, remove           robot commands
//   robot_clock                   high only in HIGH
//   head, left, under, barrier    registered sensors
//   robot_row/col/dir             current pose (1-based; N=0 S=1 E=2 W=3)
//   running                       high in every state except IDLE
//   step_count, bump_count        saturating 16-bit counters
//   trash_count                   saturating 8-bit count of removed barriers
module grid_world #(
    parameter int ROWS          = 10,
    parameter int COLS          = 20,
    parameter int HALF          = 1,
    parameter int REMOVE_CYCLES = 3,
    parameter int MAX_STEPS     = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [5:0]  init_row,
    input  logic [5:0]  init_col,
    input  logic [1:0]  init_dir,
    input  logic        load_en,
    input  logic [5:0]  load_row,
    input  logic [5:0]  load_col,
    input  logic [2:0]  load_data,
    input  logic [5:0]  rd_row,
    input  logic [5:0]  rd_col,
    output logic [2:0]  rd_cell,
    input  logic        front,
    input  logic        turn,
    input  logic        remove,
    output logic        robot_clock,
    output logic        head,
    output logic        left,
    output logic        under,
    output logic        barrier,
    output logic [5:0]  robot_row,
    output logic [5:0]  robot_col,
    output logic [1:0]  robot_dir,
    output logic        running,
    output logic [15:0] step_count,
    output logic [15:0] bump_count,
    output logic [7:0]  trash_count
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_E = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_SENSE, S_LOW, S_HIGH, S_APPLY} state_t;

    state_t      state;
    logic [15:0] half_cnt;
    logic [15:0] rm_count;
    logic [2:0]  map [ROWS][COLS];

    // Coordinates are carried in 7 bits so that row/col 0 and ROWS+1/COLS+1
    // (one step off the grid) stay distinguishable from real cells.
    function automatic logic in_range(input logic [6:0] r, input logic [6:0] c);
        return (r >= 7'd1) && (r <= 7'(ROWS)) && (c >= 7'd1) && (c <= 7'(COLS));
    endfunction

    // Off-grid cells read as 0 (empty).
    function automatic logic [2:0] cell_at(input logic [6:0] r, input logic [6:0] c);
        logic [RW-1:0] ri;
        logic [CW-1:0] ci;
        ri = RW'(r - 7'd1);
        ci = CW'(c - 7'd1);
        if (in_range(r, c)) return map[ri][ci];
        return 3'd0;
    endfunction

    // Forward and left-hand neighbour of the current pose.
    logic [6:0] fwd_row, fwd_col, lft_row, lft_col;
    always_comb begin
        fwd_row = {1'b0, robot_row};
        fwd_col = {1'b0, robot_col};
        lft_row = {1'b0, robot_row};
        lft_col = {1'b0, robot_col};
        case (robot_dir)
            DIR_N: begin fwd_row = {1'b0, robot_row} - 7'd1; lft_col = {1'b0, robot_col} - 7'd1; end
            DIR_S: begin fwd_row = {1'b0, robot_row} + 7'd1; lft_col = {1'b0, robot_col} + 7'd1; end
            DIR_E: begin fwd_col = {1'b0, robot_col} + 7'd1; lft_row = {1'b0, robot_row} - 7'd1; end
            default: begin fwd_col = {1'b0, robot_col} - 7'd1; lft_row = {1'b0, robot_row} + 7'd1; end
        endcase
    end

    logic          fwd_in, lft_in;
    logic [2:0]    fwd_val, lft_val, cur_val;
    logic [15:0]   rm_next;
    logic          rm_hit, do_clear, ld_ok, last_step;
    logic [RW-1:0] ld_ri, fwd_ri;
    logic [CW-1:0] ld_ci, fwd_ci;

    assign fwd_in   = in_range(fwd_row, fwd_col);
    assign lft_in   = in_range(lft_row, lft_col);
    assign fwd_val  = cell_at(fwd_row, fwd_col);
    assign lft_val  = cell_at(lft_row, lft_col);
    assign cur_val  = cell_at({1'b0, robot_row}, {1'b0, robot_col});
    assign rm_next  = rm_count + 16'd1;
    assign rm_hit   = rm_next >= 16'(REMOVE_CYCLES);
    // A remove only counts when front and turn are both low.
    assign do_clear = (state == S_APPLY) && !front && !turn && remove && rm_hit
                      && fwd_in && (fwd_val == 3'd2);
    assign ld_ok    = (state == S_IDLE) && load_en
                      && in_range({1'b0, load_row}, {1'b0, load_col});
    assign last_step = (MAX_STEPS != 0) && (({1'b0, step_count} + 17'd1) == 17'(MAX_STEPS));
    assign ld_ri    = RW'({1'b0, load_row} - 7'd1);
    assign ld_ci    = CW'({1'b0, load_col} - 7'd1);
    assign fwd_ri   = RW'(fwd_row - 7'd1);
    assign fwd_ci   = CW'(fwd_col - 7'd1);

    // Map storage. Loads happen only in IDLE and barrier clears only in
    // APPLY, so the two write sources never collide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    map[i][j] <= 3'd0;
        end else if (ld_ok) begin
            map[ld_ri][ld_ci] <= load_data;
        end else if (do_clear) begin
            map[fwd_ri][fwd_ci] <= 3'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            half_cnt    <= 16'd0;
            rm_count    <= 16'd0;
            rd_cell     <= 3'd0;
            robot_clock <= 1'b0;
            head        <= 1'b0;
            left        <= 1'b0;
            under       <= 1'b0;
            barrier     <= 1'b0;
            robot_row   <= 6'd1;
            robot_col   <= 6'd1;
            robot_dir   <= DIR_N;
            running     <= 1'b0;
            step_count  <= 16'd0;
            bump_count  <= 16'd0;
            trash_count <= 8'd0;
        end else begin
            // Reads the pre-write map, so a same-cycle load returns the old value.
            rd_cell <= cell_at({1'b0, rd_row}, {1'b0, rd_col});
            case (state)
                S_IDLE: begin
                    if (start) begin
                        robot_row   <= init_row;
                        robot_col   <= init_col;
                        robot_dir   <= init_dir;
                        step_count  <= 16'd0;
                        bump_count  <= 16'd0;
                        trash_count <= 8'd0;
                        rm_count    <= 16'd0;
                        running     <= 1'b1;
                        state       <= S_SENSE;
                    end
                end
                S_SENSE: begin
                    head     <= !fwd_in || (fwd_val == 3'd1);
                    left     <= !lft_in || (lft_val == 3'd1);
                    under    <= (cur_val == 3'd7);
                    barrier  <= fwd_in && (fwd_val == 3'd2);
                    half_cnt <= 16'd0;
                    state    <= S_LOW;
                end
                S_LOW: begin
                    if (half_cnt == 16'(HALF - 1)) begin
                        half_cnt    <= 16'd0;
                        robot_clock <= 1'b1;
                        state       <= S_HIGH;
                    end else begin
                        half_cnt <= half_cnt + 16'd1;
                    end
                end
                S_HIGH: begin
                    if (half_cnt == 16'(HALF - 1)) begin
                        half_cnt    <= 16'd0;
                        robot_clock <= 1'b0;
                        state       <= S_APPLY;
                    end else begin
                        half_cnt <= half_cnt + 16'd1;
                    end
                end
                S_APPLY: begin
                    if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
                    if (front) begin
                        rm_count <= 16'd0;
                        if (head || barrier) begin
                            if (bump_count != 16'hFFFF) bump_count <= bump_count + 16'd1;
                        end else begin
                            robot_row <= fwd_row[5:0];
                            robot_col <= fwd_col[5:0];
                        end
                    end else if (turn) begin
                        rm_count <= 16'd0;
                        case (robot_dir)
                            DIR_N:   robot_dir <= DIR_W;
                            DIR_W:   robot_dir <= DIR_S;
                            DIR_S:   robot_dir <= DIR_E;
                            default: robot_dir <= DIR_N;
                        endcase
                    end else if (remove) begin
                        if (rm_hit) begin
                            rm_count <= 16'd0;
                            if (do_clear && trash_count != 8'hFF)
                                trash_count <= trash_count + 8'd1;
                        end else begin
                            rm_count <= rm_next;
                        end
                    end else begin
                        rm_count <= 16'd0;
                    end
                    if (stop || last_step) begin
                        running <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_SENSE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_world.sv
// Bench for grid_world: one unlimited instance (dut) and one with a
// three-step limit (dut_lim) sharing the same stimulus.
module tb_grid_world;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, stop, front, turn, remove, load_en;
    logic [5:0]  init_row, init_col, load_row, load_col, rd_row, rd_col;
    logic [1:0]  init_dir;
    logic [2:0]  load_data;

    logic [2:0]  rd_cell;
    logic        robot_clock, head, left, under, barrier, running;
    logic [5:0]  robot_row, robot_col;
    logic [1:0]  robot_dir;
    logic [15:0] step_count, bump_count;
    logic [7:0]  trash_count;

    logic [2:0]  lim_rd_cell;
    logic        lim_robot_clock, lim_head, lim_left, lim_under, lim_barrier, lim_running;
    logic [5:0]  lim_robot_row, lim_robot_col;
    logic [1:0]  lim_robot_dir;
    logic [15:0] lim_step_count, lim_bump_count;
    logic [7:0]  lim_trash_count;

    always #5 clock = ~clock;

    grid_world #(.MAX_STEPS(0)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .init_row(init_row), .init_col(init_col), .init_dir(init_dir),
        .load_en(load_en), .load_row(load_row), .load_col(load_col), .load_data(load_data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
        .front(front), .turn(turn), .remove(remove), .robot_clock(robot_clock),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .robot_row(robot_row), .robot_col(robot_col), .robot_dir(robot_dir),
        .running(running), .step_count(step_count), .bump_count(bump_count),
        .trash_count(trash_count)
    );

    grid_world #(.MAX_STEPS(3)) dut_lim (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .init_row(init_row), .init_col(init_col), .init_dir(init_dir),
        .load_en(load_en), .load_row(load_row), .load_col(load_col), .load_data(load_data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(lim_rd_cell),
        .front(front), .turn(turn), .remove(remove), .robot_clock(lim_robot_clock),
        .head(lim_head), .left(lim_left), .under(lim_under), .barrier(lim_barrier),
        .robot_row(lim_robot_row), .robot_col(lim_robot_col), .robot_dir(lim_robot_dir),
        .running(lim_running), .step_count(lim_step_count), .bump_count(lim_bump_count),
        .trash_count(lim_trash_count)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [2:0] exp_q[$];
    logic [3:0] s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load_cell(input logic [5:0] r, input logic [5:0] c, input logic [2:0] d);
        @(negedge clock);
        load_en = 1'b1; load_row = r; load_col = c; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [5:0] r, input logic [5:0] c,
                               input logic [2:0] e);
        exp_q.push_back(e);
        @(negedge clock);
        rd_row = r; rd_col = c;
        @(posedge clock); #1;
        check(name, rd_cell, exp_q.pop_front());
    endtask

    // Returns with both instances in SENSE.
    task automatic start_robot(input logic [5:0] r, input logic [5:0] c, input logic [1:0] d);
        @(negedge clock);
        init_row = r; init_col = c; init_dir = d; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Entered just after the clock that moved dut into SENSE; returns just
    // after APPLY has taken effect. Sensors are sampled while in LOW.
    task automatic run_step(input logic f, input logic t, input logic rm, input logic st,
                            output logic [3:0] sens);
        front = f; turn = t; remove = rm; stop = st;
        @(posedge clock); #1;
        sens = {head, left, under, barrier};
        @(posedge clock); #1;
        check("robot_clock_high", robot_clock, 1);
        @(posedge clock); #1;
        check("robot_clock_apply", robot_clock, 0);
        @(posedge clock); #1;
        front = 1'b0; turn = 1'b0; remove = 1'b0; stop = 1'b0;
    endtask

    typedef struct {
        logic        new_run;
        logic [5:0]  ir, ic;
        logic [1:0]  id;
        logic        f, t, rm, st;
        logic [3:0]  sens;   // {head, left, under, barrier}
        logic [5:0]  row, col;
        logic [1:0]  dir;
        logic [15:0] steps, bumps;
        logic        run;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Empty map throughout the table. Dir codes: N=0 S=1 E=2 W=3.
        vecs[0] = '{1'b1, 6'd1,  6'd1,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 6'd1,  6'd1,  2'd3, 16'd1, 16'd0, 1'b1};
        vecs[1] = '{1'b0, 6'd0,  6'd0,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 6'd1,  6'd1,  2'd1, 16'd2, 16'd0, 1'b1};
        vecs[2] = '{1'b0, 6'd0,  6'd0,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 6'd1,  6'd1,  2'd2, 16'd3, 16'd0, 1'b1};
        vecs[3] = '{1'b0, 6'd0,  6'd0,  2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 6'd1,  6'd1,  2'd0, 16'd4, 16'd0, 1'b0};
        vecs[4] = '{1'b1, 6'd5,  6'd5,  2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 6'd5,  6'd6,  2'd2, 16'd1, 16'd0, 1'b1};
        vecs[5] = '{1'b0, 6'd0,  6'd0,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 6'd5,  6'd7,  2'd2, 16'd2, 16'd0, 1'b1};
        vecs[6] = '{1'b0, 6'd0,  6'd0,  2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 6'd5,  6'd8,  2'd2, 16'd3, 16'd0, 1'b0};
        vecs[7] = '{1'b1, 6'd10, 6'd20, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 6'd10, 6'd20, 2'd1, 16'd1, 16'd1, 1'b0};
        vecs[8] = '{1'b1, 6'd5,  6'd5,  2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 6'd4,  6'd5,  2'd0, 16'd1, 16'd0, 1'b1};
        vecs[9] = '{1'b0, 6'd0,  6'd0,  2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 6'd4,  6'd5,  2'd3, 16'd2, 16'd0, 1'b0};

        // Clock/reset
        reset = 1'b0; start = 1'b0; stop = 1'b0; front = 1'b0; turn = 1'b0; remove = 1'b0;
        load_en = 1'b0; load_row = '0; load_col = '0; load_data = '0;
        init_row = '0; init_col = '0; init_dir = '0; rd_row = 6'd1; rd_col = 6'd1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_pose", {robot_row, robot_col, robot_dir}, {6'd1, 6'd1, 2'd0});
        check("reset_flags", {running, robot_clock, head, left, under, barrier}, 0);
        check("reset_counts", {step_count, bump_count, trash_count}, 0);
        check("reset_rd_cell", rd_cell, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Table-driven steps
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].new_run) start_robot(vecs[i].ir, vecs[i].ic, vecs[i].id);
            check("running_in_sense", running, 1);
            run_step(vecs[i].f, vecs[i].t, vecs[i].rm, vecs[i].st, s);
            check($sformatf("vec%0d_sensors", i), s, vecs[i].sens);
            check($sformatf("vec%0d_pose", i), {robot_row, robot_col, robot_dir},
                  {vecs[i].row, vecs[i].col, vecs[i].dir});
            check($sformatf("vec%0d_steps", i), step_count, vecs[i].steps);
            check($sformatf("vec%0d_bumps", i), bump_count, vecs[i].bumps);
            check($sformatf("vec%0d_running", i), running, vecs[i].run);
        end

        // Wall ahead: blocked move
        load_cell(6'd4, 6'd5, 3'd1);
        start_robot(6'd5, 6'd5, 2'd0);
        run_step(1'b1, 1'b0, 1'b0, 1'b1, s);
        check("wall_sensors", s, 4'b1000);
        check("wall_pose", {robot_row, robot_col, robot_dir}, {6'd5, 6'd5, 2'd0});
        check("wall_bumps", bump_count, 1);
        load_cell(6'd4, 6'd5, 3'd0);

        // Barrier removed after three consecutive removes
        load_cell(6'd5, 6'd6, 3'd2);
        read_expect("barrier_loaded", 6'd5, 6'd6, 3'd2);
        start_robot(6'd5, 6'd5, 2'd2);
        for (int k = 0; k < 3; k++) begin
            run_step(1'b0, 1'b0, 1'b1, 1'b0, s);
            check($sformatf("remove%0d_sensors", k), s, 4'b0001);
            check($sformatf("remove%0d_trash", k), trash_count, (k == 2) ? 1 : 0);
        end
        run_step(1'b0, 1'b0, 1'b0, 1'b1, s);
        check("removed_sensors", s, 4'b0000);
        read_expect("barrier_cleared", 6'd5, 6'd6, 3'd0);

        // Interrupted remove pattern 1,1,0,1,1 leaves the barrier
        load_cell(6'd5, 6'd6, 3'd2);
        start_robot(6'd5, 6'd5, 2'd2);
        for (int k = 0; k < 5; k++) begin
            run_step(1'b0, 1'b0, (k != 2), (k == 4), s);
            check($sformatf("pattern%0d_sensors", k), s, 4'b0001);
        end
        check("pattern_trash", trash_count, 0);
        check("pattern_steps", step_count, 5);
        read_expect("pattern_cell", 6'd5, 6'd6, 3'd2);

        // Same-cycle write/read returns old value, then new value
        @(negedge clock);
        load_en = 1'b1; load_row = 6'd2; load_col = 6'd3; load_data = 3'd7;
        rd_row = 6'd2; rd_col = 6'd3;
        @(posedge clock); #1;
        check("rd_same_cycle_old", rd_cell, 0);
        @(negedge clock);
        load_en = 1'b0;
        @(posedge clock); #1;
        check("rd_after_write", rd_cell, 7);

        // Dirt under robot; load while running is ignored
        start_robot(6'd2, 6'd3, 2'd1);
        load_en = 1'b1; load_row = 6'd2; load_col = 6'd3; load_data = 3'd0;
        run_step(1'b0, 1'b0, 1'b0, 1'b1, s);
        load_en = 1'b0;
        check("dirt_sensors", s, 4'b0010);
        read_expect("load_while_running", 6'd2, 6'd3, 3'd7);
        read_expect("rd_row0", 6'd0, 6'd3, 3'd0);
        read_expect("rd_row11", 6'd11, 6'd3, 3'd0);
        read_expect("rd_col21", 6'd2, 6'd21, 3'd0);

        // Step limit of 3 on dut_lim
        load_cell(6'd5, 6'd6, 3'd0);
        start_robot(6'd5, 6'd5, 2'd2);
        for (int k = 0; k < 3; k++) begin
            run_step(1'b1, 1'b0, 1'b0, 1'b0, s);
            check($sformatf("lim%0d_col", k), lim_robot_col, 6 + k);
            check($sformatf("lim%0d_running", k), lim_running, (k < 2) ? 1 : 0);
        end
        check("lim_steps", lim_step_count, 3);
        check("unlimited_still_running", running, 1);
        run_step(1'b1, 1'b0, 1'b0, 1'b1, s);
        check("lim_stays_idle", {lim_running, lim_robot_col}, {1'b0, 6'd8});
        check("unlimited_col", robot_col, 9);

        // Reset mid-step aborts and clears the map
        start_robot(6'd5, 6'd5, 2'd2);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_flags", {running, robot_clock}, 0);
        check("abort_pose", {robot_row, robot_col, robot_dir}, {6'd1, 6'd1, 2'd0});
        @(negedge clock);
        reset = 1'b1;
        read_expect("map_cleared", 6'd2, 6'd3, 3'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
